// File: rtl/step_counter_pkg.sv
// step_counter_pkg -- shared constants and types for the step counter.
//   DIR_UP / DIR_DOWN    : encodings of dir_i
//   MODE_WRAP / MODE_SAT : encodings of mode_i
//   op_e                 : operation selected for this cycle after priority decoding
//   decode_op()          : clear > load > enable priority resolution
package step_counter_pkg;

  localparam logic DIR_DOWN  = 1'b0;
  localparam logic DIR_UP    = 1'b1;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_CLEAR = 2'd1,
    OP_LOAD  = 2'd2,
    OP_STEP  = 2'd3
  } op_e;

  function automatic op_e decode_op(input logic clear, input logic load, input logic en);
    if (clear)     return OP_CLEAR;
    else if (load) return OP_LOAD;
    else if (en)   return OP_STEP;
    else           return OP_NONE;
  endfunction

endpackage

// File: rtl/step_counter_next.sv
// step_counter_next -- combinational next-count calculation.
// Forms count +/- zero-extended step in DATA_SIZE+1 bits, reports carry/borrow,
// and (only when STEP_COUNTER_SAT_EN is defined) clamps in saturate mode.
// Ports:
//   count_i : current count
//   dir_i   : 1 = up, 0 = down
//   step_i  : unsigned step magnitude
//   mode_i  : 0 = wrap, 1 = saturate (ignored without STEP_COUNTER_SAT_EN)
//   next_o  : value to store if the step is taken
//   flow_o  : carry (up) or borrow (down) out of the DATA_SIZE-bit range
module step_counter_next
  import step_counter_pkg::*;
#(
  parameter int DATA_SIZE = 8,
  parameter int STEP_W    = 4
) (
  input  logic [DATA_SIZE-1:0] count_i,
  input  logic                 dir_i,
  input  logic [STEP_W-1:0]    step_i,
  input  logic                 mode_i,
  output logic [DATA_SIZE-1:0] next_o,
  output logic                 flow_o
);

  logic [DATA_SIZE:0] step_ext;
  logic [DATA_SIZE:0] raw;

  assign step_ext = {{(DATA_SIZE+1-STEP_W){1'b0}}, step_i};
  // Bit DATA_SIZE of the extended result is the carry on up, the borrow on down.
  assign raw      = (dir_i == DIR_UP) ? ({1'b0, count_i} + step_ext)
                                      : ({1'b0, count_i} - step_ext);
  assign flow_o   = raw[DATA_SIZE];

`ifdef STEP_COUNTER_SAT_EN
  always_comb begin
    next_o = raw[DATA_SIZE-1:0];
    if (mode_i == MODE_SAT && flow_o)
      next_o = (dir_i == DIR_UP) ? {DATA_SIZE{1'b1}} : '0;
  end
`else
  // Wrap-only build: mode_i has no effect.
  logic unused_mode;
  assign unused_mode = mode_i;
  assign next_o      = raw[DATA_SIZE-1:0];
`endif

endmodule

// File: rtl/step_counter.sv
// step_counter -- up/down counter with variable step, wrap/saturate modes,
// registered terminal-count pulse and sticky overflow flag.
// Optional feature macro: STEP_COUNTER_SAT_EN (enables saturate mode).
// Ports:
//   clk_i, rst_ni      : clock, async active-low reset
//   clear_i            : sync clear to RESET_VAL (highest priority)
//   load_i, load_val_i : sync load
//   en_i, dir_i        : count enable, direction (1 = up)
//   step_i             : step magnitude
//   mode_i             : 0 = wrap, 1 = saturate
//   tc_val_i           : terminal-count compare value
//   count_o            : registered count
//   zero_o             : combinational count_o == 0
//   tc_o               : one-cycle terminal-count pulse
//   ovf_o              : sticky overflow/underflow
module step_counter
  import step_counter_pkg::*;
#(
  parameter int                   DATA_SIZE = 8,
  parameter int                   STEP_W    = 4,
  parameter logic [DATA_SIZE-1:0] RESET_VAL = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 load_i,
  input  logic [DATA_SIZE-1:0] load_val_i,
  input  logic                 en_i,
  input  logic                 dir_i,
  input  logic [STEP_W-1:0]    step_i,
  input  logic                 mode_i,
  input  logic [DATA_SIZE-1:0] tc_val_i,
  output logic [DATA_SIZE-1:0] count_o,
  output logic                 zero_o,
  output logic                 tc_o,
  output logic                 ovf_o
);

  logic [DATA_SIZE-1:0] count_q, count_d;
  logic                 tc_q, tc_d;
  logic                 ovf_q, ovf_d;
  logic [DATA_SIZE-1:0] next;
  logic                 flow;
  op_e                  op;

  step_counter_next #(
    .DATA_SIZE(DATA_SIZE),
    .STEP_W   (STEP_W)
  ) u_next (
    .count_i(count_q),
    .dir_i  (dir_i),
    .step_i (step_i),
    .mode_i (mode_i),
    .next_o (next),
    .flow_o (flow)
  );

  assign op = decode_op(clear_i, load_i, en_i);

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    tc_d    = 1'b0;
    unique case (op)
      OP_CLEAR: begin
        count_d = RESET_VAL;
        ovf_d   = 1'b0;
      end
      OP_LOAD: begin
        count_d = load_val_i;
        ovf_d   = 1'b0;
      end
      OP_STEP: begin
        count_d = next;
        ovf_d   = ovf_q | flow;
        // Only a real change onto tc_val_i pulses; step 0 or a clamped hold does not.
        tc_d    = (next == tc_val_i) && (next != count_q);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= RESET_VAL;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);
  assign tc_o    = tc_q;
  assign ovf_o   = ovf_q;

endmodule

// File: doc/step_counter.md
STEP_COUNTER -- requirements
Module: step_counter

Interface
REQ-001 The block SHALL take parameter DATA_SIZE, default 8, as the count register width in bits (legal range 2..32).
REQ-002 The block SHALL take parameter STEP_W, default 4, as the step input width in bits (legal range 1..DATA_SIZE).
REQ-003 The block SHALL take parameter RESET_VAL, default 0, as the count value after reset and after clear_i.
REQ-004 Port clk_i, input, 1 bit: single clock; all state SHALL update on its rising edge.
REQ-005 Port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port clear_i, input, 1 bit: synchronous clear to RESET_VAL.
REQ-007 Port load_i, input, 1 bit: synchronous load of load_val_i.
REQ-008 Port load_val_i, input, DATA_SIZE bits: value to load.
REQ-009 Port en_i, input, 1 bit: count enable.
REQ-010 Port dir_i, input, 1 bit: count direction, 1 = up, 0 = down.
REQ-011 Port step_i, input, STEP_W bits: unsigned step magnitude; 0 is legal.
REQ-012 Port mode_i, input, 1 bit: 0 = wrap, 1 = saturate.
REQ-013 Port tc_val_i, input, DATA_SIZE bits: terminal-count compare value.
REQ-014 Port count_o, output, DATA_SIZE bits: registered count.
REQ-015 Port zero_o, output, 1 bit: combinational, high when count_o == 0.
REQ-016 Port tc_o, output, 1 bit: registered terminal-count pulse.
REQ-017 Port ovf_o, output, 1 bit: registered sticky overflow/underflow flag.

Function
REQ-018 The block SHALL apply operations in the priority order clear_i, then load_i, then en_i; only the highest-priority asserted operation takes effect in a cycle.
REQ-019 On clear_i, the block SHALL set count_o to RESET_VAL and clear tc_o and ovf_o on the next edge.
REQ-020 On load_i without clear_i, the block SHALL set count_o to load_val_i, clear ovf_o, and force tc_o to 0 on the next edge.
REQ-021 On en_i alone, the block SHALL form next = count_o ± zero-extended step_i in DATA_SIZE+1 bits and register the result on the next edge (latency 1 cycle).
REQ-022 In wrap mode, the block SHALL store next modulo 2^DATA_SIZE.
REQ-023 In saturate mode, an up-count carry SHALL clamp the count to 2^DATA_SIZE-1, and a down-count borrow SHALL clamp it to 0.
REQ-024 The block SHALL set ovf_o on any enabled step that carries or borrows, in either mode, and ovf_o SHALL hold until clear_i, load_i, or reset.
REQ-025 The block SHALL assert tc_o for exactly one cycle, aligned with the new count_o, when an enabled step stores a value equal to tc_val_i and that value differs from the previous count_o.
REQ-026 A step of step_i = 0, or a saturated hold at the limit, SHALL NOT re-pulse tc_o.
REQ-027 With en_i low and no clear_i or load_i, count_o, ovf_o SHALL hold, and tc_o SHALL return to 0.
REQ-028 zero_o SHALL follow count_o combinationally with no added latency.

Reset
REQ-029 When rst_ni is asserted low, the block SHALL asynchronously force count_o to RESET_VAL and tc_o and ovf_o to 0, irrespective of clk_i.
REQ-030 Reset asserted mid-count SHALL abort the count, and the first edge after deassertion SHALL honour the inputs using normal priority.

Configuration
REQ-031 With macro STEP_COUNTER_SAT_EN defined, the block SHALL honour mode_i as specified.
REQ-032 Without STEP_COUNTER_SAT_EN, the block SHALL ignore mode_i, compile no saturation logic, and always wrap; ovf_o behaviour SHALL be unchanged.

Structure
REQ-033 Package step_counter_pkg SHALL hold the direction constants DIR_UP/DIR_DOWN, the mode constants MODE_WRAP/MODE_SAT, and the priority-decoded operation enum OP_NONE/OP_CLEAR/OP_LOAD/OP_STEP.
REQ-034 The combinational next-value, carry/borrow and clamp calculation SHALL be one sub-module, step_counter_next, instantiated once; registers and tc/ovf logic SHALL reside in step_counter.

Verification (DATA_SIZE=8, STEP_W=4, RESET_VAL=0)
REQ-035 Scenario: rst_ni low mid-count at count 0x37 -> count_o=0, tc_o=0, ovf_o=0 immediately without a clock edge; zero_o=1.
REQ-036 Scenario: load 0x10; then down-count with step 3 for 5 cycles, tc_val_i=0x01 -> counts 0x0D,0x0A,0x07,0x04,0x01; tc_o=1 only in the 0x01 cycle; ovf_o=0.
REQ-037 Scenario: load 0xFE; then up-count with step 5 in wrap mode -> 0x03 and ovf_o=1, holding after en_i drops; then load 0x00 -> ovf_o=0.
REQ-038 Scenario: with STEP_COUNTER_SAT_EN, saturate mode, load 0x02, down step 7 -> count 0x00, ovf_o=1; a repeat step holds 0x00 with no tc_o re-pulse (tc_val_i=0).
REQ-039 Scenario: clear_i, load_i and en_i high in the same cycle with load_val_i=0x55 -> count_o=0x00; then load_i and en_i high together -> count_o=0x55, not 0x55±step.
REQ-040 Scenario: without STEP_COUNTER_SAT_EN, mode_i=1, load 0xFF, up step 1 -> count 0x00 (wrapped), ovf_o=1.
